// File: rtl/matrix_output_handler_if.sv
// Handshake, storage-read and buffer-write signals of the matrix read-back path.
// The master side drives the controls and returns storage data; the slave side is the handler.
interface matrix_output_handler_if;
    logic        start;
    logic [2:0]  matrix_id_in;
    logic        busy;
    logic        done;
    logic        error;
    logic [13:0] storage_rd_addr;
    logic [31:0] storage_rd_data;
    logic        buf_wr_en;
    logic [10:0] buf_wr_addr;
    logic [31:0] buf_wr_data;
    logic [10:0] words_written;

    modport master (
        output start, matrix_id_in, storage_rd_data,
        input  busy, done, error, storage_rd_addr,
               buf_wr_en, buf_wr_addr, buf_wr_data, words_written
    );

    modport slave (
        input  start, matrix_id_in, storage_rd_data,
        output busy, done, error, storage_rd_addr,
               buf_wr_en, buf_wr_addr, buf_wr_data, words_written
    );
endinterface

// File: rtl/matrix_output_handler.sv
// Copies one stored matrix slot into the output buffer as a named-matrix record:
// -1, id, name0, name1, rows, cols, data... with a gap-free write burst.
//
// state    | meaning
// IDLE     | waiting for start
// RD_HDR   | slot base address on the storage read port
// CHECK    | header word returned; validate id/rows/cols/N
// WR_MARK  | write -1 marker
// WR_ID    | write matrix id
// WR_NAME0 | write name word 0
// WR_NAME1 | write name word 1
// WR_ROWS  | write rows
// WR_COLS  | write cols
// WR_DATA  | write N data words
// DONE     | transfer complete, start accepted again
// ERROR    | bad id or header; left only by rst
module matrix_output_handler #(
    parameter int BLOCK_SIZE = 1152,
    parameter int HDR_WORDS  = 3,
    parameter int MAX_ELEMS  = 1149
) (
    input  logic                    clk,
    input  logic                    rst,
    matrix_output_handler_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE, RD_HDR, CHECK, WR_MARK, WR_ID, WR_NAME0, WR_NAME1,
        WR_ROWS, WR_COLS, WR_DATA, DONE, ERROR
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  id_q;
    logic [13:0] base_q;
    logic [13:0] rd_addr;
    logic [13:0] last_addr;
    logic [7:0]  rows_q;
    logic [7:0]  cols_q;
    logic [15:0] n_q;
    logic [15:0] rem;
    logic [31:0] name0_q;
    logic [31:0] name1_q;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [31:0] wr_data;
    logic [10:0] wr_count;

    logic [7:0]  hdr_rows;
    logic [7:0]  hdr_cols;
    logic [15:0] hdr_n;
    logic        hdr_bad;

    function automatic logic [13:0] base_of(input logic [2:0] id);
        return {11'd0, id} * 14'(BLOCK_SIZE);
    endfunction

    assign hdr_rows = bus.storage_rd_data[31:24];
    assign hdr_cols = bus.storage_rd_data[23:16];
    assign hdr_n    = {8'd0, hdr_rows} * {8'd0, hdr_cols};
    assign hdr_bad  = (id_q == 3'd0) || (hdr_rows == 8'd0) || (hdr_cols == 8'd0) ||
                      (hdr_n > 16'(MAX_ELEMS));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (bus.start) state_nxt = RD_HDR;
            RD_HDR:     state_nxt = CHECK;
            CHECK:      state_nxt = hdr_bad ? ERROR : WR_MARK;
            WR_MARK:    state_nxt = WR_ID;
            WR_ID:      state_nxt = WR_NAME0;
            WR_NAME0:   state_nxt = WR_NAME1;
            WR_NAME1:   state_nxt = WR_ROWS;
            WR_ROWS:    state_nxt = WR_COLS;
            WR_COLS:    state_nxt = WR_DATA;
            WR_DATA:    if (rem == 16'd1) state_nxt = DONE;
            ERROR:      state_nxt = ERROR;
            default:    state_nxt = IDLE;
        endcase
    end

    // Write outputs are registered: each state loads the word written in the following state.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q      <= '0;
            base_q    <= '0;
            rd_addr   <= '0;
            last_addr <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
            n_q       <= '0;
            rem       <= '0;
            name0_q   <= '0;
            name1_q   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_count  <= '0;
        end else begin
            if (wr_en) wr_count <= wr_count + 11'd1;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        id_q     <= bus.matrix_id_in;
                        base_q   <= base_of(bus.matrix_id_in);
                        rd_addr  <= base_of(bus.matrix_id_in);
                        wr_count <= '0;
                    end
                end
                RD_HDR: rd_addr <= rd_addr + 14'd1;
                CHECK: begin
                    rows_q    <= hdr_rows;
                    cols_q    <= hdr_cols;
                    n_q       <= hdr_n;
                    last_addr <= base_q + 14'(HDR_WORDS) + hdr_n[13:0] - 14'd1;
                    rd_addr   <= rd_addr + 14'd1;
                    if (!hdr_bad) begin
                        wr_en   <= 1'b1;
                        wr_addr <= '0;
                        wr_data <= 32'hFFFF_FFFF;
                    end
                end
                WR_MARK: begin
                    name0_q <= bus.storage_rd_data;
                    wr_addr <= wr_addr + 11'd1;
                    wr_data <= {29'd0, id_q};
                end
                WR_ID: begin
                    name1_q <= bus.storage_rd_data;
                    wr_addr <= wr_addr + 11'd1;
                    wr_data <= name0_q;
                end
                WR_NAME0: begin
                    wr_addr <= wr_addr + 11'd1;
                    wr_data <= name1_q;
                end
                WR_NAME1: begin
                    wr_addr <= wr_addr + 11'd1;
                    wr_data <= {24'd0, rows_q};
                    rd_addr <= base_q + 14'(HDR_WORDS);
                end
                WR_ROWS: begin
                    wr_addr <= wr_addr + 11'd1;
                    wr_data <= {24'd0, cols_q};
                    if (rd_addr != last_addr) rd_addr <= rd_addr + 14'd1;
                end
                WR_COLS: begin
                    wr_addr <= wr_addr + 11'd1;
                    wr_data <= bus.storage_rd_data;
                    rem     <= n_q;
                    if (rd_addr != last_addr) rd_addr <= rd_addr + 14'd1;
                end
                WR_DATA: begin
                    rem <= rem - 16'd1;
                    if (rd_addr != last_addr) rd_addr <= rd_addr + 14'd1;
                    if (rem != 16'd1) begin
                        wr_addr <= wr_addr + 11'd1;
                        wr_data <= bus.storage_rd_data;
                    end else begin
                        wr_en <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy            = !(state inside {IDLE, DONE, ERROR});
    assign bus.done            = (state == DONE);
    assign bus.error           = (state == ERROR);
    assign bus.storage_rd_addr = rd_addr;
    assign bus.buf_wr_en       = wr_en;
    assign bus.buf_wr_addr     = wr_addr;
    assign bus.buf_wr_data     = wr_data;
    assign bus.words_written   = wr_count;

endmodule

// File: tb/tb_matrix_output_handler.sv
// Directed bench for matrix_output_handler: storage model with 1-cycle read latency,
// buffer write logger, and hand-built expected records per slot.
module tb_matrix_output_handler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    matrix_output_handler_if bus();

    matrix_output_handler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [0:16383];
    always @(posedge clk) bus.storage_rd_data <= mem[bus.storage_rd_addr];

    int          wr_cnt = 0;
    logic [10:0] wl_addr [0:2047];
    logic [31:0] wl_data [0:2047];
    int          wl_cyc  [0:2047];

    always @(posedge clk) begin
        if (bus.buf_wr_en) begin
            if (wr_cnt < 2048) begin
                wl_addr[wr_cnt] = bus.buf_wr_addr;
                wl_data[wr_cnt] = bus.buf_wr_data;
                wl_cyc[wr_cnt]  = cyc;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // exp_n = expected write count, 0 means the run must end in ERROR.
    task automatic run(input logic [2:0] id, input int exp_n, input int inject_at);
        int          base;
        int          rows, cols, n, to, c0, gaps;
        logic [31:0] w0;
        logic [31:0] exp_w [0:2047];
        base = int'(id) * 1152;
        w0   = mem[base];
        rows = int'(w0[31:24]);
        cols = int'(w0[23:16]);
        n    = rows * cols;
        if (exp_n > 0) begin
            exp_w[0] = 32'hFFFF_FFFF;
            exp_w[1] = {29'd0, id};
            exp_w[2] = mem[base + 1];
            exp_w[3] = mem[base + 2];
            exp_w[4] = rows;
            exp_w[5] = cols;
            for (int k = 0; k < n && k < 2040; k++) exp_w[6 + k] = mem[base + 3 + k];
        end
        @(negedge clk);
        bus.start        = 1'b1;
        bus.matrix_id_in = id;
        c0     = cyc;
        wr_cnt = 0;
        @(negedge clk);
        bus.start = 1'b0;
        chk($sformatf("id%0d_c1_busy", id), bus.busy, 1);
        chk($sformatf("id%0d_c1_rd_addr", id), bus.storage_rd_addr, base);
        chk($sformatf("id%0d_c1_words_written", id), bus.words_written, 0);
        to = 0;
        while (!(bus.done || bus.error) && to < 3000) begin
            if (inject_at != 0 && cyc == c0 + inject_at) begin
                bus.start        = 1'b1;
                bus.matrix_id_in = 3'd7;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            to++;
        end
        bus.start = 1'b0;
        chk($sformatf("id%0d_no_timeout", id), (to < 3000), 1);
        if (exp_n == 0) begin
            chk($sformatf("id%0d_error", id), bus.error, 1);
            chk($sformatf("id%0d_error_cycle", id), cyc - c0, 3);
            chk($sformatf("id%0d_error_writes", id), wr_cnt, 0);
            chk($sformatf("id%0d_error_busy", id), bus.busy, 0);
        end else begin
            chk($sformatf("id%0d_done_cycle", id), cyc - c0, 9 + n);
            chk($sformatf("id%0d_writes", id), wr_cnt, exp_n);
            chk($sformatf("id%0d_words_written", id), bus.words_written, exp_n);
            gaps = 0;
            for (int i = 0; i < exp_n && i < 2048; i++) begin
                chk($sformatf("id%0d_word%0d", id, i), wl_data[i], exp_w[i]);
                if (wl_addr[i] != 11'(i) || wl_cyc[i] != c0 + 3 + i) gaps++;
            end
            chk($sformatf("id%0d_burst_shape", id), gaps, 0);
        end
    endtask

    initial begin
        int to;
        bus.start        = 1'b0;
        bus.matrix_id_in = 3'd0;
        for (int a = 0; a < 16384; a++) mem[a] = 32'd0;
        mem[0] = 32'h0101_0000;
        mem[3] = 32'd42;
        mem[1152] = 32'h1830_0000;
        mem[3456] = 32'h0203_0000;
        mem[3457] = 32'h4D41_5452;
        mem[3458] = 32'h4958_5F41;
        for (int k = 0; k < 6; k++) mem[3459 + k] = k + 1;
        mem[4608] = 32'h0404_0000;
        mem[4609] = 32'h4D41_5452;
        mem[4610] = 32'h4958_5F42;
        for (int k = 0; k < 16; k++) mem[4611 + k] = 32'h100 + k;
        mem[8064] = 32'h0101_0000;
        mem[8065] = 32'h4F4E_4531;
        mem[8066] = 32'h5F58_5F59;
        mem[8067] = 32'hFFFF_FFFB;

        do_reset();
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_wr_en", bus.buf_wr_en, 0);
        chk("rst_wr_addr", bus.buf_wr_addr, 0);
        chk("rst_wr_data", bus.buf_wr_data, 0);
        chk("rst_words_written", bus.words_written, 0);
        chk("rst_rd_addr", bus.storage_rd_addr, 0);

        run(3'd3, 12, 0);
        chk("s3_first_name_word", wl_data[2], 32'h4D41_5452);
        chk("s3_last_data", wl_data[11], 32'd6);
        run(3'd3, 12, 6);
        run(3'd7, 7, 0);
        chk("s7_last_word", wl_data[6], 32'hFFFF_FFFB);
        chk("s7_rd_addr_hold", bus.storage_rd_addr, 8067);

        do_reset();
        run(3'd5, 0, 0);
        @(negedge clk);
        bus.start        = 1'b1;
        bus.matrix_id_in = 3'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("err_sticky", bus.error, 1);
        chk("err_start_ignored_busy", bus.busy, 0);
        chk("err_start_ignored_writes", wr_cnt, 0);

        do_reset();
        run(3'd0, 0, 0);
        do_reset();
        run(3'd1, 0, 0);

        do_reset();
        @(negedge clk);
        bus.start        = 1'b1;
        bus.matrix_id_in = 3'd4;
        @(negedge clk);
        bus.start = 1'b0;
        to = 0;
        while (!(bus.buf_wr_en && bus.buf_wr_addr == 11'd9) && to < 100) begin
            @(negedge clk);
            to++;
        end
        chk("midrst_reached_4th_data", (to < 100), 1);
        chk("midrst_4th_data_value", bus.buf_wr_data, 32'h103);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_wr_en", bus.buf_wr_en, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_words_written", bus.words_written, 0);
        run(3'd4, 22, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
